calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have parameter: RES_LAT, 1, cycles from driving ALU operands to sampling alu_z/alu_v (legal 1..15).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: key_valid  in  1  one-cycle key strobe.
REQ-005 SHALL have port: key_code  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear.
REQ-006 SHALL have port: alu_x  out  18  operand A to ALU.
REQ-007 SHALL have port: alu_y  out  18  operand B to ALU.
REQ-008 SHALL have port: alu_s  out  2  op select: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 SHALL have port: alu_z  in  18  ALU result.
REQ-010 SHALL have port: alu_v  in  1  ALU overflow flag.
REQ-011 SHALL have port: disp  out  18  value shown to user.
REQ-012 SHALL have port: busy  out  1  high in EXEC; keys ignored.
REQ-013 SHALL have port: err  out  1  high in ERROR.

Function
REQ-014 SHALL implement states ENTER_A, ENTER_B, EXEC, DONE, ERROR.
REQ-015 Digit key in ENTER_A/ENTER_B SHALL update acc = acc*10 + d; if the result exceeds 262143, the digit SHALL be ignored and acc kept.
REQ-016 disp SHALL equal acc in ENTER_A/ENTER_B, the captured result in DONE, and 0 in ERROR; in EXEC it SHALL hold its last value.
REQ-017 Op key in ENTER_A SHALL latch A=acc and op, clear acc, and go to ENTER_B.
REQ-018 Op key in ENTER_B before any digit SHALL replace the latched op and stay in ENTER_B; after a digit it SHALL be ignored.
REQ-019 Equals in ENTER_B SHALL latch B=acc; if op=div and B=0, the block SHALL go to ERROR, otherwise to EXEC.
REQ-020 Equals in ENTER_A or DONE SHALL be ignored.
REQ-021 alu_x/alu_y/alu_s SHALL be registered, stable for the whole EXEC dwell, and equal to the latched A/B/op.
REQ-022 EXEC SHALL last exactly RES_LAT cycles. On the last EXEC cycle, alu_z SHALL be sampled into the result register.
REQ-023 If op is add or sub and alu_v=1 at sampling, the block SHALL go to ERROR; otherwise it SHALL go to DONE.
REQ-024 Digit key in DONE SHALL clear acc, load it with the digit, and go to ENTER_A.
REQ-025 In ERROR only clear SHALL have effect.
REQ-026 Clear in any state, including mid-EXEC, SHALL zero acc/A/B/op/result and go to ENTER_A on the next edge.
REQ-027 key_valid=0 SHALL cause no state change except the EXEC counter.

Reset
REQ-028 rst_n=0 SHALL immediately force ENTER_A with acc/A/B/result/counter=0, alu_x=alu_y=0, alu_s=00, disp=0, busy=0, err=0.
REQ-029 Reset assertion mid-EXEC SHALL abandon the operation; no result is retained.

Configuration
REQ-030 With CALC_CHAIN_EN defined, an op key in DONE SHALL latch A=result and the op, clear acc, and go to ENTER_B.
REQ-031 Without CALC_CHAIN_EN, an op key in DONE SHALL be ignored.

Verification
REQ-032 The bench SHALL cover: keys 1,2,+,7,= with RES_LAT=1 -> busy high 1 cycle, alu_x=12, alu_y=7, alu_s=00, then DONE with disp=19, err=0.
REQ-033 The bench SHALL cover: keys 1,0,0,/,0,= -> ERROR, err=1, disp=0, busy never high; then clear -> ENTER_A, err=0.
REQ-034 The bench SHALL cover: digits 2,6,2,1,4,3 then 9 -> disp stays 262143.
REQ-035 The bench SHALL cover: with CALC_CHAIN_EN, keys 6,*,7,=,+,1,= -> disp 42 then 43; without the macro, the + is ignored and disp stays 42.
REQ-036 The bench SHALL cover: RES_LAT=3, clear strobed on the 2nd EXEC cycle -> next cycle ENTER_A, busy=0, disp=0, no result captured.
REQ-037 The bench SHALL cover: an add whose ALU model returns alu_v=1 -> ERROR; rst_n pulsed low asynchronously mid-entry -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl
//
// Keypad calculator controller. It collects two decimal operands and one
// operator from a key strobe stream. It then drives an external ALU and shows
// the result.
//
// Parameters
//   RES_LAT        cycles from driving the ALU operands to sampling alu_z/alu_v
//                  (legal 1..15)
//
// Optional feature (compile-time macro)
//   CALC_CHAIN_EN  when defined, an operator key in DONE continues the
//                  calculation, with the previous result as the new operand A.
//                  When undefined, an operator key in DONE is ignored.
//
// Ports
//   clk        in   1   single clock, all state on the rising edge
//   rst_n      in   1   asynchronous active-low reset
//   key_valid  in   1   one-cycle key strobe
//   key_code   in   4   0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals,
//                       15 clear
//   alu_x      out  18  operand A to the ALU (registered)
//   alu_y      out  18  operand B to the ALU (registered)
//   alu_s      out  2   ALU op select: 00 add, 01 sub, 10 mul, 11 div
//   alu_z      in   18  ALU result
//   alu_v      in   1   ALU overflow flag
//   disp       out  18  value shown to the user (registered)
//   busy       out  1   high while the ALU operation is in flight
//   err        out  1   high in the error state
// -----------------------------------------------------------------------------
module calc_ctrl #(
    parameter int unsigned RES_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [17:0] alu_x,
    output logic [17:0] alu_y,
    output logic [1:0]  alu_s,
    input  logic [17:0] alu_z,
    input  logic        alu_v,
    output logic [17:0] disp,
    output logic        busy,
    output logic        err
);

`ifdef CALC_CHAIN_EN
    localparam logic CHAIN_EN = 1'b1;
`else
    localparam logic CHAIN_EN = 1'b0;
`endif

    // Counter value seen on the final EXEC cycle.
    localparam logic [3:0]  LAST_CNT = 4'(RES_LAT - 1);
    localparam logic [21:0] ACC_MAX  = 22'd262143;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [17:0] acc_r;
    logic [17:0] a_r;
    logic [17:0] b_r;
    logic [1:0]  op_r;
    logic [17:0] res_r;
    logic [3:0]  cnt_r;
    logic        seen_r;
    logic [17:0] alu_x_r;
    logic [17:0] alu_y_r;
    logic [1:0]  alu_s_r;
    logic [17:0] disp_r;
    logic        busy_r;
    logic        err_r;

    logic [17:0] acc_nxt_s;
    logic [17:0] a_nxt_s;
    logic [17:0] b_nxt_s;
    logic [1:0]  op_nxt_s;
    logic [17:0] res_nxt_s;
    logic [3:0]  cnt_nxt_s;
    logic        seen_nxt_s;
    logic [17:0] alu_x_nxt_s;
    logic [17:0] alu_y_nxt_s;
    logic [1:0]  alu_s_nxt_s;
    logic [17:0] disp_nxt_s;
    logic        busy_nxt_s;
    logic        err_nxt_s;

    // Key decode. The clear key acts as the synchronous soft reset.
    logic        srst_s;
    logic        dig_s;
    logic        op_s;
    logic        eq_s;
    logic [1:0]  op_code_s;
    logic [21:0] acc_mac_s;
    logic        acc_fits_s;
    logic        last_s;
    logic        div0_s;
    logic        alu_ovf_s;

    assign srst_s    = key_valid && (key_code == 4'd15);
    assign dig_s     = key_valid && (key_code <= 4'd9);
    assign op_s      = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
    assign eq_s      = key_valid && (key_code == 4'd14);
    // Key codes 10..13 map onto ALU selects 0..3. Subtracting 2 from the low
    // two bits gives that mapping without a 4-bit subtract.
    assign op_code_s = key_code[1:0] - 2'b10;

    // The widened multiply-accumulate lets a digit that would overflow be
    // detected and dropped, instead of wrapping the accumulator.
    assign acc_mac_s  = ({4'b0000, acc_r} * 22'd10) + {18'd0, key_code};
    assign acc_fits_s = (acc_mac_s <= ACC_MAX);

    assign last_s    = (cnt_r == LAST_CNT);
    assign div0_s    = (op_r == 2'b11) && (acc_r == 18'd0);
    // Overflow only matters for add and sub. Mul wraps, and div cannot overflow.
    assign alu_ovf_s = alu_v && !op_r[1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ENTER_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (srst_s) begin
            state_nxt_s = ST_ENTER_A;
        end else begin
            case (state_r)
                ST_ENTER_A: begin
                    if (op_s) begin
                        state_nxt_s = ST_ENTER_B;
                    end else begin
                        state_nxt_s = ST_ENTER_A;
                    end
                end
                ST_ENTER_B: begin
                    if (eq_s) begin
                        state_nxt_s = div0_s ? ST_ERROR : ST_EXEC;
                    end else begin
                        state_nxt_s = ST_ENTER_B;
                    end
                end
                ST_EXEC: begin
                    if (last_s) begin
                        state_nxt_s = alu_ovf_s ? ST_ERROR : ST_DONE;
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end
                ST_DONE: begin
                    if (dig_s) begin
                        state_nxt_s = ST_ENTER_A;
                    end else if (op_s && CHAIN_EN) begin
                        state_nxt_s = ST_ENTER_B;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                ST_ERROR: begin
                    state_nxt_s = ST_ERROR;
                end
                default: begin
                    state_nxt_s = ST_ENTER_A;
                end
            endcase
        end
    end

    // Datapath next values: accumulator, operands, operator, result, counter.
    always_comb begin
        acc_nxt_s   = acc_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        op_nxt_s    = op_r;
        res_nxt_s   = res_r;
        cnt_nxt_s   = cnt_r;
        seen_nxt_s  = seen_r;
        alu_x_nxt_s = alu_x_r;
        alu_y_nxt_s = alu_y_r;
        alu_s_nxt_s = alu_s_r;
        if (srst_s) begin
            acc_nxt_s   = 18'd0;
            a_nxt_s     = 18'd0;
            b_nxt_s     = 18'd0;
            op_nxt_s    = 2'b00;
            res_nxt_s   = 18'd0;
            cnt_nxt_s   = 4'd0;
            seen_nxt_s  = 1'b0;
            alu_x_nxt_s = 18'd0;
            alu_y_nxt_s = 18'd0;
            alu_s_nxt_s = 2'b00;
        end else begin
            case (state_r)
                ST_ENTER_A: begin
                    if (dig_s) begin
                        acc_nxt_s = acc_fits_s ? acc_mac_s[17:0] : acc_r;
                    end else if (op_s) begin
                        a_nxt_s    = acc_r;
                        op_nxt_s   = op_code_s;
                        acc_nxt_s  = 18'd0;
                        seen_nxt_s = 1'b0;
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end
                ST_ENTER_B: begin
                    if (dig_s) begin
                        // Any digit locks the operator, even a zero that leaves
                        // acc unchanged.
                        seen_nxt_s = 1'b1;
                        acc_nxt_s  = acc_fits_s ? acc_mac_s[17:0] : acc_r;
                    end else if (op_s) begin
                        op_nxt_s = seen_r ? op_r : op_code_s;
                    end else if (eq_s) begin
                        b_nxt_s = acc_r;
                        if (!div0_s) begin
                            // The operands are loaded here, so they stay stable
                            // for the whole EXEC dwell.
                            alu_x_nxt_s = a_r;
                            alu_y_nxt_s = acc_r;
                            alu_s_nxt_s = op_r;
                            cnt_nxt_s   = 4'd0;
                        end else begin
                            cnt_nxt_s = cnt_r;
                        end
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end
                ST_EXEC: begin
                    if (last_s) begin
                        res_nxt_s = alu_z;
                    end else begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (dig_s) begin
                        acc_nxt_s = {14'd0, key_code};
                    end else if (op_s && CHAIN_EN) begin
                        a_nxt_s    = res_r;
                        op_nxt_s   = op_code_s;
                        acc_nxt_s  = 18'd0;
                        seen_nxt_s = 1'b0;
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end
                ST_ERROR: begin
                    acc_nxt_s = acc_r;
                end
                default: begin
                    acc_nxt_s = 18'd0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= 18'd0;
            a_r     <= 18'd0;
            b_r     <= 18'd0;
            op_r    <= 2'b00;
            res_r   <= 18'd0;
            cnt_r   <= 4'd0;
            seen_r  <= 1'b0;
            alu_x_r <= 18'd0;
            alu_y_r <= 18'd0;
            alu_s_r <= 2'b00;
        end else begin
            acc_r   <= acc_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            op_r    <= op_nxt_s;
            res_r   <= res_nxt_s;
            cnt_r   <= cnt_nxt_s;
            seen_r  <= seen_nxt_s;
            alu_x_r <= alu_x_nxt_s;
            alu_y_r <= alu_y_nxt_s;
            alu_s_r <= alu_s_nxt_s;
        end
    end

    // Output logic. The outputs are decoded from the next state, so the
    // registered outputs line up with the state they describe.
    always_comb begin
        busy_nxt_s = (state_nxt_s == ST_EXEC);
        err_nxt_s  = (state_nxt_s == ST_ERROR);
        disp_nxt_s = disp_r;
        case (state_nxt_s)
            ST_ENTER_A: disp_nxt_s = acc_nxt_s;
            ST_ENTER_B: disp_nxt_s = acc_nxt_s;
            ST_EXEC:    disp_nxt_s = disp_r;
            ST_DONE:    disp_nxt_s = res_nxt_s;
            ST_ERROR:   disp_nxt_s = 18'd0;
            default:    disp_nxt_s = 18'd0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_r <= 18'd0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            disp_r <= disp_nxt_s;
            busy_r <= busy_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    assign alu_x = alu_x_r;
    assign alu_y = alu_y_r;
    assign alu_s = alu_s_r;
    assign disp  = disp_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_ctrl
//
// Bench for calc_ctrl. It runs two instances side by side, one with RES_LAT=1
// and one with RES_LAT=3. Both see the same key stream, and each has its own
// combinational ALU model. A per-instance keypad model predicts disp/busy/err
// and the ALU operands every cycle. The bench covers directed scenarios first
// and then a randomized key stream.
// -----------------------------------------------------------------------------
module tb_calc_ctrl;

`ifdef CALC_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    localparam int M_A = 0;
    localparam int M_B = 1;
    localparam int M_X = 2;
    localparam int M_D = 3;
    localparam int M_E = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        force_v = 1'b0;

    logic [17:0] alu_x_o [2];
    logic [17:0] alu_y_o [2];
    logic [1:0]  alu_s_o [2];
    logic [17:0] alu_z_i [2];
    logic        alu_v_i [2];
    logic [17:0] disp_o  [2];
    logic        busy_o  [2];
    logic        err_o   [2];
    logic [18:0] alu_r   [2];

    int n_chk = 0;
    int n_bad = 0;

    // The keypad model state for each instance.
    int m_mode [2];
    int m_acc  [2];
    int m_a    [2];
    int m_b    [2];
    int m_op   [2];
    int m_res  [2];
    int m_disp [2];
    int m_rem  [2];
    bit m_seen [2];
    int lat    [2];

    always #5 clk = ~clk;

    // ALU behaviour: {overflow, result}.
    function automatic logic [18:0] alu_fn(input logic [17:0] x, input logic [17:0] y,
                                           input logic [1:0] s);
        logic [35:0] w;
        logic [17:0] z;
        logic        v;
        w = 36'd0;
        case (s)
            2'd0: begin w = 36'(x) + 36'(y); z = w[17:0]; v = (w > 36'd262143); end
            2'd1: begin z = x - y; v = (y > x); end
            2'd2: begin w = 36'(x) * 36'(y); z = w[17:0]; v = (w > 36'd262143); end
            default: begin z = (y == 18'd0) ? 18'h3ffff : x / y; v = 1'b0; end
        endcase
        return {v, z};
    endfunction

    assign alu_r[0]   = alu_fn(alu_x_o[0], alu_y_o[0], alu_s_o[0]);
    assign alu_z_i[0] = alu_r[0][17:0];
    assign alu_v_i[0] = alu_r[0][18] | force_v;
    assign alu_r[1]   = alu_fn(alu_x_o[1], alu_y_o[1], alu_s_o[1]);
    assign alu_z_i[1] = alu_r[1][17:0];
    assign alu_v_i[1] = alu_r[1][18] | force_v;

    calc_ctrl #(.RES_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_x(alu_x_o[0]), .alu_y(alu_y_o[0]), .alu_s(alu_s_o[0]),
        .alu_z(alu_z_i[0]), .alu_v(alu_v_i[0]),
        .disp(disp_o[0]), .busy(busy_o[0]), .err(err_o[0])
    );

    calc_ctrl #(.RES_LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_x(alu_x_o[1]), .alu_y(alu_y_o[1]), .alu_s(alu_s_o[1]),
        .alu_z(alu_z_i[1]), .alu_v(alu_v_i[1]),
        .disp(disp_o[1]), .busy(busy_o[1]), .err(err_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_A; m_acc[i] = 0; m_a[i] = 0; m_b[i] = 0; m_op[i] = 0;
            m_res[i] = 0; m_disp[i] = 0; m_rem[i] = 0; m_seen[i] = 1'b0;
        end
    endtask

    // One clock edge of the keypad model.
    task automatic model_step(input bit kv, input int kc);
        logic [18:0] r;
        for (int i = 0; i < 2; i++) begin
            if (kv && kc == 15) begin
                m_mode[i] = M_A; m_acc[i] = 0; m_a[i] = 0; m_b[i] = 0;
                m_op[i] = 0; m_res[i] = 0; m_seen[i] = 1'b0;
            end else if (m_mode[i] == M_X) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    r = alu_fn(18'(m_a[i]), 18'(m_b[i]), 2'(m_op[i]));
                    m_res[i] = int'(r[17:0]);
                    m_mode[i] = (m_op[i] < 2 && (r[18] || force_v)) ? M_E : M_D;
                end
            end else if (kv) begin
                if (kc <= 9) begin
                    if (m_mode[i] == M_A || m_mode[i] == M_B) begin
                        if (m_acc[i] * 10 + kc <= 262143) m_acc[i] = m_acc[i] * 10 + kc;
                        if (m_mode[i] == M_B) m_seen[i] = 1'b1;
                    end else if (m_mode[i] == M_D) begin
                        m_acc[i] = kc; m_mode[i] = M_A;
                    end
                end else if (kc <= 13) begin
                    if (m_mode[i] == M_A || (m_mode[i] == M_D && CHAIN)) begin
                        m_a[i] = (m_mode[i] == M_A) ? m_acc[i] : m_res[i];
                        m_op[i] = kc - 10; m_acc[i] = 0; m_seen[i] = 1'b0; m_mode[i] = M_B;
                    end else if (m_mode[i] == M_B && !m_seen[i]) begin
                        m_op[i] = kc - 10;
                    end
                end else if (kc == 14 && m_mode[i] == M_B) begin
                    m_b[i] = m_acc[i];
                    if (m_op[i] == 3 && m_b[i] == 0) m_mode[i] = M_E;
                    else begin m_mode[i] = M_X; m_rem[i] = lat[i]; end
                end
            end
            case (m_mode[i])
                M_A, M_B: m_disp[i] = m_acc[i];
                M_D:      m_disp[i] = m_res[i];
                M_E:      m_disp[i] = 0;
                default:  m_disp[i] = m_disp[i];
            endcase
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("disp[%0d]", i), 32'(disp_o[i]), m_disp[i]);
            check_eq($sformatf("busy[%0d]", i), 32'(busy_o[i]), (m_mode[i] == M_X) ? 1 : 0);
            check_eq($sformatf("err[%0d]", i), 32'(err_o[i]), (m_mode[i] == M_E) ? 1 : 0);
            if (m_mode[i] == M_X) begin
                check_eq($sformatf("alu_x[%0d]", i), 32'(alu_x_o[i]), m_a[i]);
                check_eq($sformatf("alu_y[%0d]", i), 32'(alu_y_o[i]), m_b[i]);
                check_eq($sformatf("alu_s[%0d]", i), 32'(alu_s_o[i]), m_op[i]);
            end
        end
    endtask

    // This task is called at a falling edge. It drives a key, steps the model
    // at the rising edge, and compares at the next falling edge.
    task automatic tick(input bit kv, input int kc);
        key_valid = kv;
        key_code  = 4'(kc);
        @(posedge clk);
        model_step(kv, kc);
        @(negedge clk);
        key_valid = 1'b0;
        compare_all();
    endtask

    task automatic press(input int kc);
        tick(1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 0);
    endtask

    // This task pulses reset between clock edges and checks that the outputs
    // clear before any edge arrives.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s_disp[%0d]", tag, i), 32'(disp_o[i]), 0);
            check_eq($sformatf("%s_busy[%0d]", tag, i), 32'(busy_o[i]), 0);
            check_eq($sformatf("%s_err[%0d]", tag, i), 32'(err_o[i]), 0);
            check_eq($sformatf("%s_alux[%0d]", tag, i), 32'(alu_x_o[i]), 0);
            check_eq($sformatf("%s_aluy[%0d]", tag, i), 32'(alu_y_o[i]), 0);
            check_eq($sformatf("%s_alus[%0d]", tag, i), 32'(alu_s_o[i]), 0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        int kc;
        lat[0] = 1;
        lat[1] = 3;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_disp[%0d]", i), 32'(disp_o[i]), 0);
            check_eq($sformatf("rst_busy[%0d]", i), 32'(busy_o[i]), 0);
            check_eq($sformatf("rst_err[%0d]", i), 32'(err_o[i]), 0);
            check_eq($sformatf("rst_alux[%0d]", i), 32'(alu_x_o[i]), 0);
            check_eq($sformatf("rst_alus[%0d]", i), 32'(alu_s_o[i]), 0);
        end
        rst_n = 1'b1;

        // 12 + 7 with a one-cycle ALU.
        press(1); press(2); press(10); press(7); press(14);
        check_eq("add_busy", 32'(busy_o[0]), 1);
        check_eq("add_alux", 32'(alu_x_o[0]), 12);
        check_eq("add_aluy", 32'(alu_y_o[0]), 7);
        check_eq("add_alus", 32'(alu_s_o[0]), 0);
        idle(1);
        check_eq("add_busy_end", 32'(busy_o[0]), 0);
        check_eq("add_disp", 32'(disp_o[0]), 19);
        check_eq("add_err", 32'(err_o[0]), 0);
        idle(3);
        check_eq("add_disp_l3", 32'(disp_o[1]), 19);

        // Divide by zero goes straight to ERROR without entering EXEC.
        press(15);
        press(1); press(0); press(0); press(13); press(0); press(14);
        check_eq("div0_err", 32'(err_o[0]), 1);
        check_eq("div0_busy", 32'(busy_o[0]), 0);
        check_eq("div0_disp", 32'(disp_o[0]), 0);
        press(3); press(14);
        check_eq("div0_stuck", 32'(err_o[1]), 1);
        press(15);
        check_eq("div0_clr_err", 32'(err_o[0]), 0);
        check_eq("div0_clr_disp", 32'(disp_o[0]), 0);

        // Accumulator saturation: a digit that would exceed 262143 is dropped.
        press(2); press(6); press(2); press(1); press(4); press(3);
        check_eq("max_disp", 32'(disp_o[0]), 262143);
        press(9);
        check_eq("max_hold", 32'(disp_o[0]), 262143);

        // Chained operation.
        press(15);
        press(6); press(12); press(7); press(14); idle(3);
        check_eq("chain_42", 32'(disp_o[0]), 42);
        press(10);
        check_eq("chain_op", 32'(disp_o[0]), CHAIN ? 0 : 42);
        press(1); press(14); idle(3);
        check_eq("chain_43", 32'(disp_o[0]), CHAIN ? 43 : 1);
        check_eq("chain_43_l3", 32'(disp_o[1]), CHAIN ? 43 : 1);

        // Clear during the second EXEC cycle of the RES_LAT=3 instance.
        press(15);
        press(5); press(10); press(4); press(14);
        idle(1);
        check_eq("mid_busy", 32'(busy_o[1]), 1);
        press(15);
        check_eq("mid_clr_busy", 32'(busy_o[1]), 0);
        check_eq("mid_clr_disp", 32'(disp_o[1]), 0);
        press(14); idle(3);
        check_eq("mid_no_res", 32'(disp_o[1]), 0);

        // Forced ALU overflow on an add.
        force_v = 1'b1;
        press(3); press(10); press(4); press(14);
        check_eq("ovf_busy", 32'(busy_o[0]), 1);
        idle(1);
        check_eq("ovf_err", 32'(err_o[0]), 1);
        check_eq("ovf_disp", 32'(disp_o[0]), 0);
        idle(2);
        check_eq("ovf_err_l3", 32'(err_o[1]), 1);
        force_v = 1'b0;
        press(15);

        // Asynchronous reset during entry, then during EXEC.
        press(7); press(8);
        check_eq("entry_disp", 32'(disp_o[0]), 78);
        pulse_reset("rst_entry");
        idle(1);
        press(2); press(10); press(3); press(14);
        idle(1);
        pulse_reset("rst_exec");
        idle(3);
        check_eq("rst_exec_disp", 32'(disp_o[1]), 0);

        // Randomized key stream.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rnd_rst");
            end
            force_v = ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 50)      kc = int'($urandom_range(0, 9));
            else if (r < 72) kc = int'($urandom_range(10, 13));
            else if (r < 93) kc = 14;
            else             kc = 15;
            tick($urandom_range(0, 3) != 0, kc);
        end
        force_v = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
